// File: rtl/rv_mc_seq.sv
// Multi-cycle sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB
// and drives one phase of datapath control per cycle. Memory handshakes are req/ack
// with a bounded wait; illegal opcodes and timeouts halt with a sticky error.
module rv_mc_seq #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic [6:0]       opcode_i,
    input  logic             imem_ack_i,
    input  logic             dmem_ack_i,
    output logic             imem_req_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic             branch_o,
    output logic             dmem_req_o,
    output logic             dmem_we_o,
    output logic             mem_to_reg_o,
    output logic [1:0]       alu_op_o,
    output logic             alu_src_o,
    output logic             reg_write_o,
    output logic             busy_o,
    output logic             err_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instret_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_R  = 3'd0,
        C_I  = 3'd1,
        C_LD = 3'd2,
        C_ST = 3'd3,
        C_BR = 3'd4,
        C_J  = 3'd5
    } cls_t;

    // Last wait count that may still see an ack before the request is abandoned.
    localparam logic [7:0] WAIT_LIM = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    cls_t             cls_q, cls_d;
    logic [7:0]       wait_q, wait_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;

    // State, class, wait counter, error flag and retire counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cls_q     <= C_R;
            wait_q    <= '0;
            err_q     <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            err_q     <= err_d;
            instret_q <= instret_d;
        end
    end

    // Next-state and per-phase control outputs; everything defaults to idle/hold.
    always_comb begin
        state_d      = state_q;
        cls_d        = cls_q;
        wait_d       = wait_q;
        err_d        = err_q;
        instret_d    = instret_q;
        retire       = 1'b0;
        imem_req_o   = 1'b0;
        ir_we_o      = 1'b0;
        pc_we_o      = 1'b0;
        branch_o     = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        alu_op_o     = 2'b00;
        alu_src_o    = 1'b0;
        reg_write_o  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    ir_we_o = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LIM) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_DECODE: begin
                state_d = S_EXEC;
                case (opcode_i)
                    7'b0110011: cls_d = C_R;
                    7'b0010011: cls_d = C_I;
                    7'b0000011: cls_d = C_LD;
                    7'b0100011: cls_d = C_ST;
                    7'b1100011: cls_d = C_BR;
                    7'b1101111: cls_d = C_J;
                    default: begin
                        state_d = S_HALT;
                        err_d   = 1'b1;
                    end
                endcase
            end
            S_EXEC: begin
                case (cls_q)
                    C_R: begin
                        alu_op_o = 2'b10;
                        state_d  = S_WB;
                    end
                    C_I: begin
                        alu_src_o = 1'b1;
                        state_d   = S_WB;
                    end
                    C_LD, C_ST: begin
                        alu_src_o = 1'b1;
                        state_d   = S_MEM;
                        wait_d    = '0;
                    end
                    C_BR: begin
                        alu_op_o = 2'b01;
                        branch_o = 1'b1;
                        pc_we_o  = 1'b1;
                        retire   = 1'b1;
                    end
                    C_J: begin
                        // Reserved jump: only advances the PC by 4.
                        pc_we_o = 1'b1;
                        retire  = 1'b1;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                // Only loads and stores reach MEM; keep the address ALU setup.
                alu_src_o  = 1'b1;
                dmem_req_o = 1'b1;
                dmem_we_o  = (cls_q == C_ST);
                if (dmem_ack_i) begin
                    if (cls_q == C_ST) begin
                        pc_we_o = 1'b1;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LIM) begin
                    state_d = S_HALT;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_WB: begin
                reg_write_o  = 1'b1;
                pc_we_o      = 1'b1;
                mem_to_reg_o = (cls_q == C_LD);
                retire       = 1'b1;
            end
            S_HALT: begin
            end
            default: state_d = S_IDLE;
        endcase

        // Retirement is the only point besides IDLE where run_i is sampled.
        if (retire) begin
            instret_d = instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_d   = run_i ? S_FETCH : S_IDLE;
            wait_d    = '0;
        end
    end

    assign busy_o    = (state_q != S_IDLE) && (state_q != S_HALT);
    assign err_o     = err_q;
    assign state_o   = state_q;
    assign instret_o = instret_q;

endmodule
